vanilla_remote_req_buffer: RTL and testbench
============================================

Name: vanilla_remote_req_buffer

Overview:
- Sits directly downstream of the vanilla core's load/store unit and upstream of the network TX endpoint.
- Captures remote requests (icache fetch, remote load/store, AMO, CBO) into a small in-order FIFO.
- Presents the requests to the network with a valid/yumi handshake.
- Enforces an outstanding-request credit limit, returns backpressure to EXE, and reports idle status for fences.

Parameters:
- els_p, 2, FIFO depth in entries; power of two, at least 2.
- max_out_credits_p, 32, maximum number of requests that may be in flight (accepted into the FIFO but not yet responded to).
- credit_width_lp, clog2(max_out_credits_p+1), width of the credit counter (localparam).
- req_width_lp, $bits(remote_req_s), packed request width (localparam).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  synchronous, active-low reset.
- remote_req_i  in  req_width_lp  request from the LSU.
- remote_req_v_i  in  1  request valid from the LSU.
- ready_o  out  1  buffer can accept this cycle. EXE stalls when remote_req_v_i=1 and ready_o=0.
- remote_req_o  out  req_width_lp  head entry, to network TX.
- remote_req_v_o  out  1  head entry valid.
- remote_req_yumi_i  in  1  network consumed head this cycle; legal only when remote_req_v_o=1.
- credit_return_i  in  1  one response or acknowledgement returned from the network.
- out_credits_o  out  credit_width_lp  credits currently available.
- idle_o  out  1  FIFO empty and all credits returned; used for fence.

Behaviour:
- Reset (reset_n_i=0 sampled at posedge):
  - read pointer, write pointer and entry count are cleared to 0.
  - out_credits is set to max_out_credits_p.
  - Outputs after reset: remote_req_v_o=0, ready_o=1, out_credits_o=max_out_credits_p, idle_o=1. remote_req_o is don't-care.
  - Reset mid-operation discards all buffered entries and restores all credits.
  - credit_return_i and remote_req_yumi_i are ignored while reset_n_i=0.
- Enqueue:
  - Occurs when remote_req_v_i & ready_o. The entry is written at wptr and wptr advances modulo els_p.
  - ready_o = (count < els_p) & (out_credits > count), using registered state only. There is no combinational path from remote_req_yumi_i or credit_return_i to ready_o.
  - When full, ready_o=0 even if a yumi arrives in the same cycle. This is deliberately conservative.
- Dequeue:
  - remote_req_v_o = (count != 0). remote_req_o is the entry at rptr, output straight from storage with no bypass.
  - Minimum latency from enqueue to remote_req_v_o is 1 cycle.
  - On remote_req_yumi_i, rptr advances modulo els_p.
- Count next value = count + enq - deq. Simultaneous enqueue and dequeue leaves the count unchanged.
- Credits:
  - A credit is consumed at dequeue (yumi), not at enqueue.
  - Next value = out_credits - yumi + credit_return_i. A simultaneous yumi and return leaves it unchanged.
  - Queued entries are counted against credits through the ready_o term, so out_credits never underflows.
- Credit overflow: credit_return_i when out_credits == max_out_credits_p is an error.
  - The counter holds at max.
  - A simulation-only assertion fires: "[BSG_ERROR] credit overflow".
- Yumi without valid is an error.
  - The state does not change.
  - A simulation assertion fires.
- idle_o = (count==0) & (out_credits==max_out_credits_p), registered state only.
- Ordering is strictly FIFO. Icache fetches get no priority over data requests.
- Pointer wrap: both pointers wrap from els_p-1 to 0. Full and empty are distinguished by count, not by pointer equality.

Optional Feature:
- Macro: VANILLA_REMOTE_REQ_PERF_EN.
- With the macro defined, two extra output ports are present:
  - stall_full_cnt_o [31:0]: counts cycles where remote_req_v_i=1, ready_o=0 and count==els_p.
  - stall_credit_cnt_o [31:0]: counts cycles where remote_req_v_i=1, ready_o=0 and count<els_p.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Without the macro, these ports and counters do not exist and core behaviour is identical.

Test Plan:
- Reset then idle: hold reset_n_i=0 for 3 cycles, then release. Expect:
  - ready_o=1, remote_req_v_o=0, out_credits_o=32, idle_o=1.
- Pass-through:
  - Enqueue req A at cycle 0. Expect remote_req_v_o=1 and remote_req_o=A at cycle 1.
  - Assert yumi at cycle 1. Expect out_credits_o=31 and idle_o=0 at cycle 2.
  - Pulse credit_return_i once. Expect out_credits_o=32 and idle_o=1.
- Full FIFO (els_p=2):
  - Enqueue A and B with yumi held low. Expect ready_o=0 in cycle 2.
  - Present C together with yumi in the same cycle. Expect C not accepted and A dequeued.
  - Next cycle: expect ready_o=1, C accepted, order at output B then C.
- Credit exhaustion (max_out_credits_p=4):
  - Send 4 requests, all yumi'd with no returns. Expect out_credits_o=0 and ready_o=0 with an empty FIFO.
  - With the perf macro on, expect stall_credit_cnt_o to increment each cycle remote_req_v_i stays high.
  - One credit_return_i gives ready_o=1 next cycle.
- Simultaneous events: at out_credits=10 with count=1, assert yumi, credit_return_i and a new enqueue in one cycle. Expect:
  - out_credits=10, count=1, and the new entry becomes head.
- Reset mid-operation: with 2 entries queued and out_credits=28, assert reset_n_i=0 for 1 cycle. Expect:
  - count=0, out_credits_o=32, remote_req_v_o=0.
  - A credit_return_i pulse during reset is ignored and no overflow assertion fires.

Source files
------------

// File: rtl/vanilla_remote_req_buffer.sv
// Remote request buffer between the vanilla core LSU and the network TX endpoint:
// in-order FIFO, valid/yumi handshake, outstanding-credit limit and fence idle.
// Optional stall counters are enabled with the macro VANILLA_REMOTE_REQ_PERF_EN.

package vanilla_remote_req_pkg;

  typedef enum logic [2:0] {
    e_req_icache = 3'd0,
    e_req_load   = 3'd1,
    e_req_store  = 3'd2,
    e_req_amo    = 3'd3,
    e_req_cbo    = 3'd4
  } remote_req_op_e;

  typedef struct packed {
    remote_req_op_e op;
    logic [31:0]    addr;
    logic [31:0]    data;
    logic [3:0]     mask;
    logic [4:0]     reg_id;
  } remote_req_s;

endpackage

module vanilla_remote_req_buffer
  import vanilla_remote_req_pkg::*;
#(
  parameter int els_p             = 2,
  parameter int max_out_credits_p = 32,
  localparam int credit_width_lp  = $clog2(max_out_credits_p + 1),
  localparam int req_width_lp     = $bits(remote_req_s)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic [req_width_lp-1:0]    remote_req_i,
  input  logic                       remote_req_v_i,
  output logic                       ready_o,

  output logic [req_width_lp-1:0]    remote_req_o,
  output logic                       remote_req_v_o,
  input  logic                       remote_req_yumi_i,

  input  logic                       credit_return_i,
  output logic [credit_width_lp-1:0] out_credits_o,
  output logic                       idle_o
`ifdef VANILLA_REMOTE_REQ_PERF_EN
  ,
  output logic [31:0]                stall_full_cnt_o,
  output logic [31:0]                stall_credit_cnt_o
`endif
);

  localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int count_width_lp = $clog2(els_p + 1);

  localparam logic [count_width_lp-1:0]  els_lp         = count_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0]    last_ptr_lp    = ptr_width_lp'(els_p - 1);
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  logic [req_width_lp-1:0]    mem_r [els_p];
  logic [ptr_width_lp-1:0]    rptr_r, wptr_r;
  logic [count_width_lp-1:0]  count_r, count_n;
  logic [credit_width_lp-1:0] out_credits_r, out_credits_n;

  logic enq, deq, credit_at_max;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
    return (ptr == last_ptr_lp) ? '0 : ptr + 1'b1;
  endfunction

  // Entries already queued will each need a credit at dequeue, so they are
  // reserved here; this is what keeps out_credits from ever underflowing.
  assign ready_o = (count_r < els_lp) && (32'(out_credits_r) > 32'(count_r));

  assign enq           = remote_req_v_i & ready_o;
  assign deq           = remote_req_yumi_i & (count_r != '0);
  assign credit_at_max = (out_credits_r == max_credits_lp);

  assign remote_req_v_o = (count_r != '0);
  assign remote_req_o   = mem_r[rptr_r];
  assign out_credits_o  = out_credits_r;
  assign idle_o         = (count_r == '0) && credit_at_max;

  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_n = count_r;
    unique case ({enq, deq})
      2'b10:   count_n = count_r + 1'b1;
      2'b01:   count_n = count_r - 1'b1;
      default: count_n = count_r;
    endcase

    out_credits_n = out_credits_r;
    if (deq && !credit_return_i)
      out_credits_n = out_credits_r - 1'b1;
    else if (!deq && credit_return_i && !credit_at_max)
      out_credits_n = out_credits_r + 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rptr_r        <= '0;
      wptr_r        <= '0;
      count_r       <= '0;
      out_credits_r <= max_credits_lp;
    end else begin
      if (enq) wptr_r <= ptr_inc(wptr_r);
      if (deq) rptr_r <= ptr_inc(rptr_r);
      count_r       <= count_n;
      out_credits_r <= out_credits_n;
    end
  end

  // NOTE: the storage array has no reset; count_r alone says which entries are live.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= remote_req_i;
  end

`ifdef VANILLA_REMOTE_REQ_PERF_EN
  logic stall_full, stall_credit;

  assign stall_full   = remote_req_v_i && !ready_o && (count_r == els_lp);
  assign stall_credit = remote_req_v_i && !ready_o && (count_r <  els_lp);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stall_full_cnt_o   <= '0;
      stall_credit_cnt_o <= '0;
    end else begin
      if (stall_full && (stall_full_cnt_o != '1))
        stall_full_cnt_o <= stall_full_cnt_o + 1'b1;
      if (stall_credit && (stall_credit_cnt_o != '1))
        stall_credit_cnt_o <= stall_credit_cnt_o + 1'b1;
    end
  end
`else
  // Stall counters are not built; the core datapath is unaffected.
`endif

`ifndef SYNTHESIS
  credit_overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(credit_return_i && credit_at_max))
    else $error("[BSG_ERROR] credit overflow");

  yumi_without_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(remote_req_yumi_i && (count_r == '0)))
    else $error("[BSG_ERROR] yumi without valid");
`endif

endmodule

// File: tb/tb_vanilla_remote_req_buffer.sv
// Self-checking bench for vanilla_remote_req_buffer: directed scenarios with literal
// expectations, then randomized traffic compared each cycle against a queue model.

module tb_vanilla_remote_req_buffer;
  import vanilla_remote_req_pkg::*;

  localparam int W    = $bits(remote_req_s);
  localparam int ELS  = 2;
  localparam int MAXC = 32;
  localparam int CW   = $clog2(MAXC + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  req_i = '0;
  logic          v_i = 1'b0, yumi = 1'b0, ret = 1'b0;
  logic          ready, v_o, idle;
  logic [W-1:0]  req_o;
  logic [CW-1:0] credits;
`ifdef VANILLA_REMOTE_REQ_PERF_EN
  logic [31:0]   stall_full_cnt, stall_credit_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vanilla_remote_req_buffer #(.els_p(ELS), .max_out_credits_p(MAXC)) dut (
    .clk_i             (clk),
    .reset_n_i         (rst_n),
    .remote_req_i      (req_i),
    .remote_req_v_i    (v_i),
    .ready_o           (ready),
    .remote_req_o      (req_o),
    .remote_req_v_o    (v_o),
    .remote_req_yumi_i (yumi),
    .credit_return_i   (ret),
    .out_credits_o     (credits),
    .idle_o            (idle)
`ifdef VANILLA_REMOTE_REQ_PERF_EN
    ,
    .stall_full_cnt_o  (stall_full_cnt),
    .stall_credit_cnt_o(stall_credit_cnt)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending requests and a plain integer credit pool.
  logic [W-1:0] m_q[$];
  int           m_credits = MAXC;
  bit           m_valid = 1'b0;
  int unsigned  m_stall_full = 0, m_stall_credit = 0;

  function automatic bit m_ready();
    return (m_q.size() < ELS) && (m_credits > m_q.size());
  endfunction

  always @(posedge clk) begin
    bit enq, deq;
    int nc;
    if (!rst_n) begin
      m_q.delete();
      m_credits      = MAXC;
      m_stall_full   = 0;
      m_stall_credit = 0;
      m_valid        = 1'b1;
    end else begin
      enq = v_i && m_ready();
      deq = yumi && (m_q.size() > 0);
      if (v_i && !m_ready()) begin
        if (m_q.size() == ELS) m_stall_full++;
        else                   m_stall_credit++;
      end
      if (deq) void'(m_q.pop_front());
      if (enq) m_q.push_back(req_i);
      nc = m_credits - int'(deq) + int'(ret);
      m_credits = (nc > MAXC) ? MAXC : nc;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", ready, m_ready());
      check("valid", v_o, m_q.size() != 0);
      if (m_q.size() != 0) check("head", req_o, m_q[0]);
      check("credits", credits, m_credits);
      check("idle", idle, (m_q.size() == 0) && (m_credits == MAXC));
`ifdef VANILLA_REMOTE_REQ_PERF_EN
      check("stall_full", stall_full_cnt, m_stall_full);
      check("stall_credit", stall_credit_cnt, m_stall_credit);
`endif
    end
  end

  function automatic logic [W-1:0] rnd_req();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Inputs change on the falling edge and are sampled by the DUT on the next rising edge.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit y, input bit r);
    v_i = v; req_i = d; yumi = y; ret = r;
    @(negedge clk);
    v_i = 1'b0; yumi = 1'b0; ret = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, b, c, x, y;
    a = rnd_req(); b = rnd_req(); c = rnd_req(); x = rnd_req(); y = rnd_req();

    // Reset held for three cycles, then idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", ready, 1'b1);
    check("rst_valid", v_o, 1'b0);
    check("rst_credits", credits, 32);
    check("rst_idle", idle, 1'b1);

    // Pass-through with one-cycle latency, credit taken at yumi.
    drive(1, a, 0, 0);
    check("pt_valid", v_o, 1'b1);
    check("pt_head", req_o, a);
    check("pt_idle_busy", idle, 1'b0);
    drive(0, '0, 1, 0);
    check("pt_credits_31", credits, 31);
    check("pt_idle_out", idle, 1'b0);
    drive(0, '0, 0, 1);
    check("pt_credits_32", credits, 32);
    check("pt_idle_back", idle, 1'b1);

    // Full FIFO: C presented with yumi is refused, accepted next cycle.
    drive(1, a, 0, 0);
    drive(1, b, 0, 0);
    check("full_ready", ready, 1'b0);
    check("full_head", req_o, a);
    drive(1, c, 1, 0);
    check("full_head_b", req_o, b);
    check("full_ready_again", ready, 1'b1);
    drive(1, c, 0, 0);
    check("full_ready_c", ready, 1'b0);
    drive(0, '0, 1, 0);
    check("full_head_c", req_o, c);
    drive(0, '0, 1, 0);
    check("full_empty", v_o, 1'b0);
    check("full_credits", credits, 29);
    repeat (3) drive(0, '0, 0, 1);

    // Credit exhaustion.
    repeat (MAXC) begin
      drive(1, rnd_req(), 0, 0);
      drive(0, '0, 1, 0);
    end
    check("exh_credits", credits, 0);
    check("exh_ready", ready, 1'b0);
    check("exh_valid", v_o, 1'b0);
    repeat (3) drive(1, rnd_req(), 0, 0);
`ifdef VANILLA_REMOTE_REQ_PERF_EN
    check("exh_stall_credit", stall_credit_cnt, 3);
    check("exh_stall_full", stall_full_cnt, 1);
`endif
    drive(0, '0, 0, 1);
    check("exh_ready_after_return", ready, 1'b1);
    check("exh_credits_1", credits, 1);
    repeat (MAXC - 1) drive(0, '0, 0, 1);
    check("exh_restored", credits, 32);

    // Simultaneous yumi, return and enqueue at credits=10, count=1.
    repeat (22) begin
      drive(1, rnd_req(), 0, 0);
      drive(0, '0, 1, 0);
    end
    drive(1, x, 0, 0);
    check("sim_pre_credits", credits, 10);
    drive(1, y, 1, 1);
    check("sim_credits", credits, 10);
    check("sim_head", req_o, y);
    check("sim_valid", v_o, 1'b1);
    drive(0, '0, 1, 0);
    repeat (23) drive(0, '0, 0, 1);

    // Reset mid-operation with a credit return ignored during reset.
    repeat (4) begin
      drive(1, rnd_req(), 0, 0);
      drive(0, '0, 1, 0);
    end
    drive(1, a, 0, 0);
    drive(1, b, 0, 0);
    check("mid_pre_credits", credits, 28);
    check("mid_pre_ready", ready, 1'b0);
    rst_n = 1'b0;
    drive(0, '0, 0, 1);
    rst_n = 1'b1;
    check("mid_valid", v_o, 1'b0);
    check("mid_credits", credits, 32);
    check("mid_ready", ready, 1'b1);
    check("mid_idle", idle, 1'b1);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      bit v, yu, r;
      rst_n = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 99) < 60);
      yu = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      r  = (m_credits < MAXC) && ($urandom_range(0, 99) < 35);
      drive(v, rnd_req(), yu, r);
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
